// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control-unit selects, ALU result, memory port and the
// decoded instruction fields handed to the control unit.
interface fetch_unit_if;
    logic [1:0]  pc_sel;
    logic        mem_sel;
    logic [1:0]  inst_sel;
    logic [31:0] alu_out;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] pc;
    logic [31:0] pc_dec;
    logic [31:0] pc_dec_p4;
    logic [31:0] inst;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;
    logic        misalign;
    logic [31:0] instret;

    // Fetch unit side.
    modport slave (
        input  pc_sel, mem_sel, inst_sel, alu_out, mem_rdata,
        output mem_addr, pc, pc_dec, pc_dec_p4, inst, opcode, func3, func7,
               rd, rs1, rs2, illegal, misalign, instret
    );

    // Control unit / memory side.
    modport master (
        output pc_sel, mem_sel, inst_sel, alu_out, mem_rdata,
        input  mem_addr, pc, pc_dec, pc_dec_p4, inst, opcode, func3, func7,
               rd, rs1, rs2, illegal, misalign, instret
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, shared memory address mux,
// decode-instruction select and field split, retired-fetch counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.slave bus
);
    localparam logic [1:0] PcP4  = 2'd0;
    localparam logic [1:0] PcAlu = 2'd1;
    localparam logic [1:0] PcOld = 2'd2;
    localparam logic [1:0] PcM4  = 2'd3;

    localparam logic [1:0] InstMem = 2'd0;
    localparam logic [1:0] InstOld = 2'd2;

    logic [31:0] pc_fetch_q, pc_fetch_d;
    logic [31:0] pc_dec_q;
    logic [31:0] inst_q;
    logic [31:0] instret_q;
    logic        fetch_q;
    logic [31:0] inst;

    // Next fetch PC; jump targets always have bit 0 cleared.
    always_comb begin
        pc_fetch_d = pc_fetch_q;
        unique case (bus.pc_sel)
            PcP4:    pc_fetch_d = pc_fetch_q + 32'd4;
            PcAlu:   pc_fetch_d = {bus.alu_out[31:1], 1'b0};
            PcOld:   pc_fetch_d = pc_fetch_q;
            PcM4:    pc_fetch_d = pc_fetch_q - 32'd4;
            default: pc_fetch_d = pc_fetch_q;
        endcase
    end

    // Instruction entering decode; reset and the reserved select inject a NOP.
    always_comb begin
        inst = NOP_INST;
        if (!rst) begin
            case (bus.inst_sel)
                InstMem: inst = bus.mem_rdata;
                InstOld: inst = inst_q;
                default: inst = NOP_INST;
            endcase
        end
    end

    // Fetch state; fetch_q marks that last cycle's memory read was an
    // instruction fetch, so only those are counted as accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_fetch_q <= RESET_PC;
            pc_dec_q   <= RESET_PC;
            inst_q     <= NOP_INST;
            fetch_q    <= 1'b0;
            instret_q  <= 32'd0;
        end else begin
            pc_fetch_q <= pc_fetch_d;
            inst_q     <= inst;
            fetch_q    <= ~bus.mem_sel;
            // Synchronous memory: the PC fetched now pairs with next cycle's data.
            if (bus.inst_sel != InstOld) begin
                pc_dec_q <= pc_fetch_q;
            end
            if (bus.inst_sel == InstMem && fetch_q) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign bus.mem_addr  = bus.mem_sel ? bus.alu_out : pc_fetch_q;
    assign bus.pc        = pc_fetch_q;
    assign bus.pc_dec    = pc_dec_q;
    assign bus.pc_dec_p4 = pc_dec_q + 32'd4;
    assign bus.inst      = inst;
    assign bus.opcode    = inst[6:2];
    assign bus.func3     = inst[14:12];
    assign bus.func7     = inst[31:25];
    assign bus.rd        = inst[11:7];
    assign bus.rs1       = inst[19:15];
    assign bus.rs2       = inst[24:20];
    assign bus.illegal   = (inst[1:0] != 2'b11);
    assign bus.misalign  = (bus.pc_sel == PcAlu) && bus.alu_out[1];
    assign bus.instret   = instret_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(32'h0000_0013)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  pc_sel;
        logic        mem_sel;
        logic [1:0]  inst_sel;
        logic [31:0] alu_out;
        logic [31:0] mem_rdata;
        // Before the clock edge.
        logic [31:0] exp_mem_addr;
        logic [31:0] exp_inst;
        logic        exp_illegal;
        logic        exp_misalign;
        logic [31:0] exp_pc_dec;
        // After the clock edge.
        logic [31:0] exp_pc;
        logic [31:0] exp_instret;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] ei;

        // rst pc_sel mem_sel inst_sel alu rdata | mem_addr inst ill mis pc_dec | pc instret
        // Straight-line fetch after reset: NOP slot, then memory.
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 2'd1, 32'h0, 32'h0,
                     32'h0, 32'h13, 1'b0, 1'b0, 32'h0, 32'h4, 32'd0};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0050_0093,
                     32'h4, 32'h0050_0093, 1'b0, 1'b0, 32'h0, 32'h8, 32'd1};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0010_0113,
                     32'h8, 32'h0010_0113, 1'b0, 1'b0, 32'h4, 32'hC, 32'd2};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0000_2183,
                     32'hC, 32'h0000_2183, 1'b0, 1'b0, 32'h8, 32'h10, 32'd3};
        // Load phase 0 then phase 1.
        vecs[4]  = '{1'b0, 2'd3, 1'b1, 2'd2, 32'h200, 32'hAAAA_5555,
                     32'h200, 32'h0000_2183, 1'b0, 1'b0, 32'hC, 32'hC, 32'd3};
        vecs[5]  = '{1'b0, 2'd0, 1'b0, 2'd1, 32'h0, 32'hAAAA_5555,
                     32'hC, 32'h13, 1'b0, 1'b0, 32'hC, 32'h10, 32'd3};
        // Refetch returns an illegal word.
        vecs[6]  = '{1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0,
                     32'h10, 32'h0, 1'b1, 1'b0, 32'hC, 32'h14, 32'd4};
        // Jumps: bit 0 cleared, bit 1 flags misalign but still taken.
        vecs[7]  = '{1'b0, 2'd1, 1'b0, 2'd0, 32'h101, 32'h0000_006F,
                     32'h14, 32'h0000_006F, 1'b0, 1'b0, 32'h10, 32'h100, 32'd5};
        vecs[8]  = '{1'b0, 2'd1, 1'b0, 2'd1, 32'h102, 32'h0,
                     32'h100, 32'h13, 1'b0, 1'b1, 32'h14, 32'h102, 32'd5};
        // Store: pc holds, data access does not count as a fetch.
        vecs[9]  = '{1'b0, 2'd2, 1'b1, 2'd0, 32'h300, 32'h0011_2023,
                     32'h300, 32'h0011_2023, 1'b0, 1'b0, 32'h100, 32'h102, 32'd6};
        vecs[10] = '{1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h13,
                     32'h102, 32'h13, 1'b0, 1'b0, 32'h102, 32'h106, 32'd6};
        // PC wrap in both directions.
        vecs[11] = '{1'b0, 2'd1, 1'b0, 2'd1, 32'hFFFF_FFFC, 32'h0,
                     32'h106, 32'h13, 1'b0, 1'b0, 32'h102, 32'hFFFF_FFFC, 32'd6};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 2'd1, 32'h0, 32'h0,
                     32'hFFFF_FFFC, 32'h13, 1'b0, 1'b0, 32'h106, 32'h0, 32'd6};
        vecs[13] = '{1'b0, 2'd3, 1'b0, 2'd1, 32'h0, 32'h0,
                     32'h0, 32'h13, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd6};
        // Reset in the middle of an OLD-hold cycle.
        vecs[14] = '{1'b0, 2'd1, 1'b0, 2'd0, 32'h41, 32'h0050_0093,
                     32'hFFFF_FFFC, 32'h0050_0093, 1'b0, 1'b0, 32'h0, 32'h40, 32'd7};
        vecs[15] = '{1'b1, 2'd0, 1'b0, 2'd2, 32'h0, 32'h0,
                     32'h40, 32'h13, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'd0};
        vecs[16] = '{1'b0, 2'd2, 1'b0, 2'd2, 32'h202, 32'h0,
                     32'h0, 32'h13, 1'b0, 1'b0, 32'h0, 32'h0, 32'd0};

        // Hand-written reset: outputs during reset, state after one edge.
        @(negedge clk);
        rst           = 1'b1;
        bus.pc_sel    = 2'd0;
        bus.mem_sel   = 1'b0;
        bus.inst_sel  = 2'd0;
        bus.alu_out   = 32'h0;
        bus.mem_rdata = 32'h0;
        #1;
        check("rst.inst", bus.inst, 32'h13);
        check("rst.illegal", {31'd0, bus.illegal}, 32'd0);
        check("rst.opcode", {27'd0, bus.opcode}, 32'd4);
        @(posedge clk);
        #1;
        check("rst.pc", bus.pc, 32'h0);
        check("rst.pc_dec", bus.pc_dec, 32'h0);
        check("rst.pc_dec_p4", bus.pc_dec_p4, 32'h4);
        check("rst.instret", bus.instret, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            bus.pc_sel    = vecs[i].pc_sel;
            bus.mem_sel   = vecs[i].mem_sel;
            bus.inst_sel  = vecs[i].inst_sel;
            bus.alu_out   = vecs[i].alu_out;
            bus.mem_rdata = vecs[i].mem_rdata;
            #1;
            ei = vecs[i].exp_inst;
            check($sformatf("v%0d.mem_addr", i), bus.mem_addr, vecs[i].exp_mem_addr);
            check($sformatf("v%0d.inst", i), bus.inst, ei);
            check($sformatf("v%0d.illegal", i), {31'd0, bus.illegal},
                  {31'd0, vecs[i].exp_illegal});
            check($sformatf("v%0d.misalign", i), {31'd0, bus.misalign},
                  {31'd0, vecs[i].exp_misalign});
            check($sformatf("v%0d.pc_dec", i), bus.pc_dec, vecs[i].exp_pc_dec);
            check($sformatf("v%0d.pc_dec_p4", i), bus.pc_dec_p4,
                  vecs[i].exp_pc_dec + 32'd4);
            check($sformatf("v%0d.opcode", i), {27'd0, bus.opcode}, {27'd0, ei[6:2]});
            check($sformatf("v%0d.rd", i), {27'd0, bus.rd}, {27'd0, ei[11:7]});
            check($sformatf("v%0d.func3", i), {29'd0, bus.func3}, {29'd0, ei[14:12]});
            check($sformatf("v%0d.rs1", i), {27'd0, bus.rs1}, {27'd0, ei[19:15]});
            check($sformatf("v%0d.rs2", i), {27'd0, bus.rs2}, {27'd0, ei[24:20]});
            check($sformatf("v%0d.func7", i), {25'd0, bus.func7}, {25'd0, ei[31:25]});
            @(posedge clk);
            #1;
            check($sformatf("v%0d.pc", i), bus.pc, vecs[i].exp_pc);
            check($sformatf("v%0d.instret", i), bus.instret, vecs[i].exp_instret);
        end

        // Spot checks of the first decoded instruction (addi x1,x0,5).
        @(negedge clk);
        rst           = 1'b0;
        bus.pc_sel    = 2'd2;
        bus.mem_sel   = 1'b0;
        bus.inst_sel  = 2'd0;
        bus.alu_out   = 32'h0;
        bus.mem_rdata = 32'h0050_0093;
        #1;
        check("addi.opcode", {27'd0, bus.opcode}, 32'd4);
        check("addi.rd", {27'd0, bus.rd}, 32'd1);
        check("addi.func3", {29'd0, bus.func3}, 32'd0);
        check("addi.illegal", {31'd0, bus.illegal}, 32'd0);
        // NOP select masks an illegal memory word.
        bus.mem_rdata = 32'h0;
        #1;
        check("zero.illegal_mem", {31'd0, bus.illegal}, 32'd1);
        bus.inst_sel = 2'd1;
        #1;
        check("zero.illegal_nop", {31'd0, bus.illegal}, 32'd0);
        bus.inst_sel = 2'd3;
        #1;
        check("reserved.inst", bus.inst, 32'h13);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
